rx_char_fifo: RTL and testbench
===============================

# rx_char_fifo

Receive-side character buffer directly downstream of the UART receiver. It captures each completed character, presented as an 8-bit value plus a one-cycle completion strobe, into a circular FIFO. Characters are offered to the consumer logic through a first-word-fall-through valid/ready interface. Overflow is reported with a sticky flag so that lost characters are never silent.

## Interface
- DEPTH, 16, number of character slots; power of 2, minimum 2.
- HIGH_WATER, 12, occupancy threshold for o_almost_full; range 1..DEPTH. Used only when RX_CHAR_FIFO_ALMOST_FULL_EN is defined.
- i_clk  in  1  system clock, 23.04 MHz.
- i_rst  in  1  asynchronous, active-low reset.
- i_char  in  8  received character; valid only in the cycle i_finished is high.
- i_finished  in  1  one-cycle push strobe from the receiver.
- o_data  out  8  head-of-queue character.
- o_valid  out  1  queue non-empty; o_data is meaningful.
- i_ready  in  1  consumer accepts o_data; a pop occurs when o_valid && i_ready.
- o_count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- o_overflow  out  1  sticky; set when a push is dropped.
- i_clr_ovf  in  1  synchronous clear of o_overflow.
- o_almost_full  out  1  present only when RX_CHAR_FIFO_ALMOST_FULL_EN is defined.

## Operation
- Storage is an array of DEPTH bytes with write and read pointers of $clog2(DEPTH)+1 bits each.
  - The low bits index the array.
  - The MSB is the wrap bit.
  - o_count = wr_ptr - rd_ptr, computed modulo 2^($clog2(DEPTH)+1).
  - Empty: pointers are equal.
  - Full: low bits are equal and MSBs differ.
- Push request = i_finished. Pop = o_valid && i_ready.
- A push is accepted when the queue is not full, or when it is full and a pop occurs in the same cycle.
  - An accepted push writes i_char at wr_ptr and increments wr_ptr.
- A push that is not accepted is dropped: i_char is discarded, the pointers are unchanged, and o_overflow is set.
- A pop increments rd_ptr. A pop while empty is impossible because o_valid is low.
- Simultaneous push and pop: both take effect and o_count is unchanged. This holds at every occupancy, including full.
- Push into an empty queue with i_ready high: no pop that cycle; the character appears on the next cycle.
- o_overflow: set has priority over i_clr_ovf in the same cycle. Otherwise i_clr_ovf clears it, and it holds its value in all other cycles.
- o_data = mem[rd_ptr low bits], a combinational read. Its value is don't-care when o_valid is low.
- Reset (asynchronous, any time, including mid-burst):
  - Pointers go to 0, giving o_count 0 and o_valid 0.
  - o_overflow goes to 0 and o_almost_full goes to 0.
  - Memory contents are not reset; o_data is don't-care.

## Timing
- Push-to-visible latency is 1 cycle. i_finished high in cycle N gives o_valid high and o_data = that character from cycle N+1.
- Pop takes effect at the clock edge: after a pop in cycle N, o_data shows the next entry in cycle N+1.
- o_count, o_valid, and o_almost_full are derived combinationally from the registered pointers. They change only after clock edges.
- o_overflow is registered. It rises in the cycle after the dropped push.
- Sustained rate: one push and one pop per cycle. The receiver's push rate (at most one character per 1000 clocks) is far below this.

## Configuration
- Macro: RX_CHAR_FIFO_ALMOST_FULL_EN.
- Defined:
  - o_almost_full port exists.
  - o_almost_full = (o_count >= HIGH_WATER).
  - Intended for flow-control logic such as RTS deassertion.
- Undefined:
  - The port and the comparison are absent.
  - HIGH_WATER is ignored.
  - All other behaviour is identical.

## Structure
- Shared package uart_pkg:
  - typedef logic [7:0] char_t, used for i_char, o_data, and the memory.
  - Constant RX_FIFO_DEPTH_DEFAULT = 16.
  - Constant RX_FIFO_HIGH_WATER_DEFAULT = 12.
- Sub-module rx_char_fifo_mem holds the storage: DEPTH x char_t register array, one synchronous write port, one asynchronous read port.
- Pointer logic, flag logic, and overflow logic stay in rx_char_fifo.

## Test plan
- Reset, then push 0x41, 0x42, 0x43 on separate strobes with i_ready=0:
  - o_count = 3 and o_data = 0x41.
  - Then raise i_ready for 3 cycles: data appears in the order 0x41, 0x42, 0x43; o_valid falls and o_count = 0.
- Push DEPTH characters 0x00..0x0F with i_ready=0, then push 0xFF:
  - 0xFF is dropped and o_count stays 16.
  - o_overflow rises the cycle after the 0xFF push.
  - Draining yields 0x00..0x0F only.
- With the queue full, assert push 0xAA and pop in the same cycle:
  - o_count stays 16 and o_overflow stays 0.
  - 0xAA emerges last.
- With o_overflow = 1, assert i_clr_ovf together with a dropped push: o_overflow remains 1. Next cycle, i_clr_ovf alone gives o_overflow = 0.
- Wrap-around: 40 push/pop pairs with random data and random i_ready gaps.
  - Output order matches a scoreboard and o_count never exceeds DEPTH.
  - With RX_CHAR_FIFO_ALMOST_FULL_EN defined, o_almost_full is 1 exactly when o_count >= 12.
- Assert i_rst low mid-burst with o_count = 5:
  - o_valid, o_count, and o_overflow go to 0 immediately.
  - After release, the first push reappears alone.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART types and defaults: character type and receive-FIFO sizing.
package uart_pkg;
  typedef logic [7:0] char_t;

  localparam int RX_FIFO_DEPTH_DEFAULT      = 16;
  localparam int RX_FIFO_HIGH_WATER_DEFAULT = 12;
endpackage

// File: rtl/rx_char_fifo_mem.sv
// Character storage for rx_char_fifo: DEPTH x char_t, one synchronous write port, one asynchronous read port.
// Write lands at the clock edge; the read port follows i_raddr combinationally. No backpressure; no reset on contents.
module rx_char_fifo_mem
  import uart_pkg::*;
#(
  parameter  int DEPTH = RX_FIFO_DEPTH_DEFAULT,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  char_t         i_wdata,
  input  logic [AW-1:0] i_raddr,
  output char_t         o_rdata
);

  char_t mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/rx_char_fifo.sv
// Receive character FIFO with first-word-fall-through valid/ready output, 1-cycle push-to-visible, sticky overflow.
// Pushes into a full queue are dropped unless a pop happens that cycle; optional o_almost_full under RX_CHAR_FIFO_ALMOST_FULL_EN.
module rx_char_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH      = RX_FIFO_DEPTH_DEFAULT,
  parameter  int HIGH_WATER = RX_FIFO_HIGH_WATER_DEFAULT,
  localparam int AW         = $clog2(DEPTH),
  localparam int PW         = AW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  char_t         i_char,
  input  logic          i_finished,
  output char_t         o_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [PW-1:0] o_count,
  output logic          o_overflow,
  input  logic          i_clr_ovf
`ifdef RX_CHAR_FIFO_ALMOST_FULL_EN
  ,
  output logic          o_almost_full
`endif
);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          ovf_q, ovf_d;
  logic          empty, full, pop, push_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign o_valid = !empty;
  assign o_count = wr_ptr_q - rd_ptr_q;
  assign pop     = o_valid && i_ready;
  // A pop frees the head slot at the same edge, so a full queue can still take a push.
  assign push_ok = i_finished && (!full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (i_finished && !push_ok) begin
      ovf_d = 1'b1;
    end else if (i_clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  assign o_overflow = ovf_q;

`ifdef RX_CHAR_FIFO_ALMOST_FULL_EN
  assign o_almost_full = (o_count >= PW'(HIGH_WATER));
`else
  // HIGH_WATER has no role without the almost-full output.
  localparam int unused_high_water = HIGH_WATER;
`endif

  rx_char_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (push_ok),
    .i_waddr (wr_ptr_q[AW-1:0]),
    .i_wdata (i_char),
    .i_raddr (rd_ptr_q[AW-1:0]),
    .o_rdata (o_data)
  );

endmodule

// File: tb/tb_rx_char_fifo.sv
// Directed bench for rx_char_fifo: vector table for basic push/pop, hand sequences for full/overflow/wrap/reset.
module tb_rx_char_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  char_t         i_char = '0;
  logic          i_finished = 1'b0;
  logic          i_ready = 1'b0;
  logic          i_clr_ovf = 1'b0;
  char_t         o_data;
  logic          o_valid;
  logic [CW-1:0] o_count;
  logic          o_overflow;
`ifdef RX_CHAR_FIFO_ALMOST_FULL_EN
  logic          o_almost_full;
`endif

  always #5 i_clk = ~i_clk;

  rx_char_fifo #(
    .DEPTH      (DEPTH),
    .HIGH_WATER (12)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_char     (i_char),
    .i_finished (i_finished),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_count    (o_count),
    .o_overflow (o_overflow),
    .i_clr_ovf  (i_clr_ovf)
`ifdef RX_CHAR_FIFO_ALMOST_FULL_EN
    ,
    .o_almost_full (o_almost_full)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; return #1 after the rising edge.
  task automatic step(input logic push, input char_t ch, input logic rdy, input logic clr);
    @(negedge i_clk);
    i_finished = push;
    i_char     = ch;
    i_ready    = rdy;
    i_clr_ovf  = clr;
    @(posedge i_clk);
    #1;
    i_finished = 1'b0;
    i_ready    = 1'b0;
    i_clr_ovf  = 1'b0;
  endtask

  task automatic chk_state(input string nm, input logic v, input int cnt, input logic ovf);
    chk({nm, "_valid"}, 32'(o_valid), 32'(v));
    chk({nm, "_count"}, 32'(o_count), 32'(cnt));
    chk({nm, "_ovf"},   32'(o_overflow), 32'(ovf));
  endtask

  typedef struct {
    logic       push;
    logic [7:0] ch;
    logic       rdy;
    logic       clr;
    logic       ev;
    logic [7:0] ed;
    logic [4:0] ec;
    logic       eo;
    logic       cd;
  } vec_t;

  vec_t vt[10];
  char_t sb[$];

  initial begin
    //        push  ch     rdy   clr   valid data   cnt  ovf   chk_data
    vt[0] = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b1, 8'h41, 5'd1, 1'b0, 1'b1};
    vt[1] = '{1'b1, 8'h42, 1'b0, 1'b0, 1'b1, 8'h41, 5'd2, 1'b0, 1'b1};
    vt[2] = '{1'b1, 8'h43, 1'b0, 1'b0, 1'b1, 8'h41, 5'd3, 1'b0, 1'b1};
    vt[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h42, 5'd2, 1'b0, 1'b1};
    vt[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h43, 5'd1, 1'b0, 1'b1};
    vt[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};
    vt[6] = '{1'b1, 8'h44, 1'b1, 1'b0, 1'b1, 8'h44, 5'd1, 1'b0, 1'b1};
    vt[7] = '{1'b1, 8'h45, 1'b1, 1'b0, 1'b1, 8'h45, 5'd1, 1'b0, 1'b1};
    vt[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};
    vt[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 1'b0};

    // Reset state while reset is held, before any clock edge.
    #3;
    chk_state("reset", 1'b0, 0, 1'b0);
    @(negedge i_clk);
    i_rst = 1'b1;

    // Basic push/pop ordering, including push into empty with ready high.
    for (int i = 0; i < 10; i++) begin
      step(vt[i].push, vt[i].ch, vt[i].rdy, vt[i].clr);
      chk($sformatf("vec%0d_valid", i), 32'(o_valid), 32'(vt[i].ev));
      chk($sformatf("vec%0d_count", i), 32'(o_count), 32'(vt[i].ec));
      chk($sformatf("vec%0d_ovf", i),   32'(o_overflow), 32'(vt[i].eo));
      if (vt[i].cd) chk($sformatf("vec%0d_data", i), 32'(o_data), 32'(vt[i].ed));
    end

    // Fill to DEPTH, then drop a push.
    for (int i = 0; i < DEPTH; i++) step(1'b1, char_t'(i), 1'b0, 1'b0);
    chk_state("full", 1'b1, DEPTH, 1'b0);
    chk("full_head", 32'(o_data), 32'h00);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    chk_state("drop", 1'b1, DEPTH, 1'b1);
    // Set beats clear when both happen together.
    step(1'b1, 8'h77, 1'b0, 1'b1);
    chk_state("set_vs_clr", 1'b1, DEPTH, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk_state("clr", 1'b1, DEPTH, 1'b0);
    // Push and pop together while full.
    step(1'b1, 8'hAA, 1'b1, 1'b0);
    chk_state("full_pushpop", 1'b1, DEPTH, 1'b0);
    for (int i = 1; i < DEPTH; i++) begin
      chk($sformatf("drain%0d", i), 32'(o_data), 32'(i));
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("drain_last", 32'(o_data), 32'hAA);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk_state("drained", 1'b0, 0, 1'b0);

    // Wrap-around with random data and random ready gaps against a scoreboard.
    begin
      int   pushed = 0;
      int   cyc    = 0;
      logic rdy, psh;
      char_t ch;
      while ((pushed < 40 || sb.size() != 0) && cyc < 3000) begin
        @(negedge i_clk);
        cyc++;
        chk("wrap_valid", 32'(o_valid), 32'(sb.size() != 0));
        chk("wrap_count", 32'(o_count), 32'(sb.size()));
        chk("wrap_le_depth", 32'(o_count <= CW'(DEPTH)), 32'd1);
        chk("wrap_ovf", 32'(o_overflow), 32'd0);
        if (sb.size() != 0) chk("wrap_data", 32'(o_data), 32'(sb[0]));
`ifdef RX_CHAR_FIFO_ALMOST_FULL_EN
        chk("wrap_afull", 32'(o_almost_full), 32'(sb.size() >= 12));
`endif
        rdy = ($urandom_range(0, 3) == 0) || (pushed >= 40);
        psh = (pushed < 40) && ($urandom_range(0, 1) == 1) && (sb.size() < DEPTH);
        ch  = char_t'($urandom_range(0, 255));
        step(psh, ch, rdy, 1'b0);
        if (rdy && sb.size() != 0) void'(sb.pop_front());
        if (psh) begin
          sb.push_back(ch);
          pushed++;
        end
      end
      chk("wrap_done", 32'(pushed == 40 && sb.size() == 0), 32'd1);
    end

    // Asynchronous reset mid-burst with five entries and overflow set.
    for (int i = 0; i < DEPTH; i++) step(1'b1, char_t'(8'h20 + i), 1'b0, 1'b0);
    step(1'b1, 8'h99, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk_state("pre_rst", 1'b1, 5, 1'b1);
    @(negedge i_clk);
    #2;
    i_rst = 1'b0;
    #1;
    chk_state("mid_rst", 1'b0, 0, 1'b0);
    @(negedge i_clk);
    i_rst = 1'b1;
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    chk_state("post_rst", 1'b1, 1, 1'b0);
    chk("post_rst_data", 32'(o_data), 32'h5A);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk_state("post_rst_pop", 1'b0, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
